// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the multiplier request arbiter.
// The MULT_ARB_TIMEOUT_EN build macro enables the BUSY watchdog in the top module.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_W              = 8;
    localparam int DEF_TIMEOUT_CYCLES = 32;
    localparam int WD_W               = 8;

endpackage

// File: rtl/mult_request_arbiter_rr_grant.sv
// Combinational rotate-priority picker: searches from the index after ptr_i,
// wrapping modulo NUM_REQ, and returns a one-hot grant plus its index.
module rr_grant #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Walk from the farthest offset to the nearest so the nearest requester wins.
    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = cand[ID_W-1:0];
                any_o         = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/mult_request_arbiter.sv
// Round-robin front end for one shared shift-add multiplier, one op in flight.
// Define MULT_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with rsp_err=1.
module mult_request_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int W              = DEF_W,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_result,
    output logic                 rsp_err,
    output logic                 mul_rst,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_result,
    input  logic                 mul_end_op
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [2*W-1:0]      result_q, result_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic                gnt_any_s;
    logic [W-1:0]        sel_a_s;
    logic [W-1:0]        sel_b_s;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0]     wd_q, wd_d;
`endif

    rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt_s),
        .idx_o   (gnt_idx_s),
        .any_o   (gnt_any_s)
    );

    // Operand mux for the winning requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_a_s = req_a[i*W +: W];
                sel_b_s = req_b[i*W +: W];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    assign req_ready  = (state_q == IDLE) ? gnt_s : '0;
    assign rsp_valid  = (state_q == RESP);
    assign mul_rst    = (state_q != BUSY);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;

    // Next-state and datapath update for IDLE -> BUSY -> RESP -> IDLE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wd_d     = (state_q == BUSY) ? wd_q + WD_W'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any_s) begin
                    state_d = BUSY;
                    ptr_d   = gnt_idx_s;
                    id_d    = gnt_idx_s;
                    a_d     = sel_a_s;
                    b_d     = sel_b_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mul_end_op) begin
                    result_d = mul_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                // wd_d counts BUSY cycles including this one.
                else if (wd_d == WD_LIMIT) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
`endif
                else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any op and rewinds the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_request_arbiter.sv
// Directed bench for mult_request_arbiter with a behavioural 19-cycle multiplier.
module tb_mult_request_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        mul_rst;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_result;
    logic        mul_end_op;

    logic [4:0]  mcnt;
    logic        stuck;

    int n_chk;
    int n_fail;

    mult_request_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_rst    (mul_rst),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_end_op (mul_end_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: end_op registered 19 clocks after release from reset.
    always_ff @(posedge clk or posedge mul_rst) begin
        if (mul_rst) mcnt <= 5'd0;
        else if (mcnt != 5'd19) mcnt <= mcnt + 5'd1;
    end
    assign mul_end_op = (mcnt == 5'd19) && !stuck;
    assign mul_result = (mcnt == 5'd19) ? ({8'd0, mul_a} * {8'd0, mul_b}) : 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: grant check, accept, latency, response, optional stall, handshake.
    task automatic run_op(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] eid, input logic [15:0] eres, input int hold,
                          input string name);
        int cyc;
        logic [3:0] onehot;
        logic [7:0] ea;
        logic [7:0] eb;
        onehot = 4'b0001 << eid;
        ea = a[eid*8 +: 8];
        eb = b[eid*8 +: 8];
        req_valid = mask;
        req_a = a;
        req_b = b;
        #1;
        check({name, " req_ready"}, {28'd0, req_ready}, {28'd0, onehot});
        tick();
        req_valid = mask & ~onehot;
        check({name, " mul_a"}, {24'd0, mul_a}, {24'd0, ea});
        check({name, " mul_b"}, {24'd0, mul_b}, {24'd0, eb});
        check({name, " mul_rst busy"}, {31'd0, mul_rst}, 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, 32'd20);
        check({name, " rsp_id"}, {30'd0, rsp_id}, {30'd0, eid});
        check({name, " rsp_result"}, {16'd0, rsp_result}, {16'd0, eres});
        check({name, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check({name, " req_ready resp"}, {28'd0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            check({name, " hold result"}, {16'd0, rsp_result}, {16'd0, eres});
            check({name, " hold ready"}, {28'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        check({name, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  eid;
        logic [15:0] eres;
        int          hold;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int cyc;
        int seen;
        n_chk = 0;
        n_fail = 0;
        stuck = 1'b0;
        rst = 1'b1;
        req_valid = 4'b0000;
        req_a = 32'd0;
        req_b = 32'd0;
        rsp_ready = 1'b0;

        // mask, {a3,a2,a1,a0}, {b3,b2,b1,b0}, expected id, expected product, stall cycles
        tbl[0] = '{4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3}, 2'd0, 16'd6, 0};
        tbl[1] = '{4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3}, 2'd1, 16'd9, 0};
        tbl[2] = '{4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3}, 2'd2, 16'd12, 0};
        tbl[3] = '{4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3}, 2'd3, 16'd15, 0};
        tbl[4] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd12}, {8'd0, 8'd0, 8'd0, 8'd13}, 2'd0, 16'd156, 0};
        tbl[5] = '{4'b0010, {8'd0, 8'd0, 8'd255, 8'd0}, {8'd0, 8'd0, 8'd255, 8'd0}, 2'd1, 16'd65025, 10};
        tbl[6] = '{4'b0101, {8'd0, 8'd7, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd0}, 2'd2, 16'd63, 0};
        tbl[7] = '{4'b0101, {8'd0, 8'd7, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd200}, 2'd0, 16'd0, 0};
        tbl[8] = '{4'b1000, {8'd1, 8'd0, 8'd0, 8'd0}, {8'd255, 8'd0, 8'd0, 8'd0}, 2'd3, 16'd255, 0};
        tbl[9] = '{4'b1001, {8'd1, 8'd0, 8'd0, 8'd128}, {8'd255, 8'd0, 8'd0, 8'd2}, 2'd0, 16'd256, 0};

        #12;
        check("reset req_ready", {28'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_id", {30'd0, rsp_id}, 32'd0);
        check("reset rsp_result", {16'd0, rsp_result}, 32'd0);
        check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset mul_rst", {31'd0, mul_rst}, 32'd1);
        check("reset mul_a", {24'd0, mul_a}, 32'd0);
        check("reset mul_b", {24'd0, mul_b}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].eid, tbl[i].eres, tbl[i].hold,
                   $sformatf("vec%0d", i));
        end

        // Requester withdraws before accept: grant moves within the same cycle.
        req_valid = 4'b0100;
        #1;
        check("withdraw first", {28'd0, req_ready}, 32'd4);
        req_valid = 4'b0010;
        #1;
        check("withdraw regrant", {28'd0, req_ready}, 32'd2);
        req_valid = 4'b0000;
        #1;
        check("withdraw none", {28'd0, req_ready}, 32'd0);

        // Reset five cycles into BUSY discards the op and rewinds the pointer.
        req_valid = 4'b0100;
        req_a = {8'd0, 8'd9, 8'd0, 8'd0};
        req_b = {8'd0, 8'd9, 8'd0, 8'd0};
        tick();
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) tick();
        check("midop busy", {31'd0, mul_rst}, 32'd0);
        rst = 1'b1;
        #1;
        check("midop mul_rst", {31'd0, mul_rst}, 32'd1);
        check("midop rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("midop no response", seen, 32'd0);
        check("midop parked", {31'd0, mul_rst}, 32'd1);
        run_op(4'b1111, {8'd5, 8'd4, 8'd3, 8'd10}, {8'd3, 8'd3, 8'd3, 8'd10}, 2'd0, 16'd100, 0,
               "post_rst");

        // req2 held with req0 also asking: service must alternate.
        run_op(4'b0101, {8'd0, 8'd6, 8'd0, 8'd1}, {8'd0, 8'd6, 8'd0, 8'd1}, 2'd2, 16'd36, 0, "fair0");
        run_op(4'b0101, {8'd0, 8'd6, 8'd0, 8'd2}, {8'd0, 8'd6, 8'd0, 8'd2}, 2'd0, 16'd4, 0, "fair1");
        run_op(4'b0101, {8'd0, 8'd6, 8'd0, 8'd3}, {8'd0, 8'd6, 8'd0, 8'd3}, 2'd2, 16'd36, 0, "fair2");
        run_op(4'b0101, {8'd0, 8'd6, 8'd0, 8'd4}, {8'd0, 8'd6, 8'd0, 8'd4}, 2'd0, 16'd16, 0, "fair3");

        // Multiplier never finishes.
        stuck = 1'b1;
        req_valid = 4'b0100;
        req_a = {8'd0, 8'd7, 8'd0, 8'd0};
        req_b = {8'd0, 8'd7, 8'd0, 8'd0};
        #1;
        check("stuck grant", {28'd0, req_ready}, 32'd4);
        tick();
        req_valid = 4'b0000;
`ifdef MULT_ARB_TIMEOUT_EN
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("timeout latency", cyc, 32'd32);
        check("timeout rsp_err", {31'd0, rsp_err}, 32'd1);
        check("timeout result", {16'd0, rsp_result}, 32'd0);
        check("timeout rsp_id", {30'd0, rsp_id}, 32'd2);
        check("timeout parked", {31'd0, mul_rst}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("timeout drop", {31'd0, rsp_valid}, 32'd0);
`else
        seen = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("stuck no response", seen, 32'd0);
        check("stuck still busy", {31'd0, mul_rst}, 32'd0);
        check("stuck rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stuck recovered", {31'd0, mul_rst}, 32'd1);
`endif
        stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
